// File: rtl/line_shift_ctrl.sv
// Sequencing controller that turns a single-clock line FIFO into a one-line pixel delay.
// Latency: fifo_wr_en/fifo_wr_data/fifo_rd_en are combinational; pixel outputs lag i_de by exactly 1 cycle.
// Backpressure: none, so 1 pixel/clk with gaps anywhere; FIFO full/empty misuse is flagged on o_err, never stalled.
//
// Build option: define LINE_SHIFT_ERR_EN to build the sticky error detector; otherwise o_err is tied 0.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset (shared with the FIFO)
//   i_vs, i_de, i_data            frame-start pulse, pixel valid, pixel
//   fifo_wr_en, fifo_wr_data      FIFO write side (combinational)
//   fifo_rd_en                    FIFO read strobe (combinational); fifo_rd_data valid one cycle later
//   fifo_rd_data, fifo_wr_full,
//   fifo_rd_empty                 FIFO read data and status
//   o_de, o_data_cur, o_col,
//   o_row, o_prev_valid           registered current-pixel outputs
//   o_data_prev                   previous-line pixel, passed straight through from fifo_rd_data
//   o_err                         sticky error flag
module line_shift_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 1920,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_vs,
  input  logic                  i_de,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_wr_full,
  input  logic                  fifo_rd_empty,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data_cur,
  output logic [DATA_WIDTH-1:0] o_data_prev,
  output logic                  o_prev_valid,
  output logic [CNT_WIDTH-1:0]  o_col,
  output logic [CNT_WIDTH-1:0]  o_row,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(LINE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_MAX  = '1;

  state_t                  state_q;
  logic [CNT_WIDTH-1:0]    col_q, col_d;
  logic [CNT_WIDTH-1:0]    row_q, row_d;
  logic                    o_de_q;
  logic [DATA_WIDTH-1:0]   o_data_cur_q;
  logic                    o_prev_valid_q;
  logic [CNT_WIDTH-1:0]    o_col_q;
  logic [CNT_WIDTH-1:0]    o_row_q;
  logic                    pix_acc;
  logic                    in_line;

  // A pixel is only taken while a line is being built or delayed; a
  // simultaneous i_vs wins and silently drops it.
  assign in_line = (state_q == FILL) || (state_q == RUN);
  assign pix_acc = i_de && !i_vs && in_line;

  assign fifo_wr_en   = pix_acc;
  assign fifo_wr_data = pix_acc ? i_data : '0;
  // DRAIN throws away whatever the previous frame left behind; RUN pops the
  // pixel one line back in lock-step with the push, so occupancy stays at
  // LINE_WIDTH between pixels.
  assign fifo_rd_en   = (state_q == DRAIN) ? !fifo_rd_empty
                                           : (pix_acc && (state_q == RUN));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if ((state_q == DRAIN) && fifo_rd_empty) begin
      col_d = '0;
      row_d = '0;
    end else if (pix_acc) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q != ROW_MAX) begin
          row_d = row_q + CNT_WIDTH'(1);
        end
      end else begin
        col_d = col_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      o_de_q         <= 1'b0;
      o_data_cur_q   <= '0;
      o_prev_valid_q <= 1'b0;
      o_col_q        <= '0;
      o_row_q        <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;

      // One register stage so the current pixel lines up with fifo_rd_data.
      o_de_q         <= pix_acc;
      o_prev_valid_q <= pix_acc && (state_q == RUN);
      if (pix_acc) begin
        o_data_cur_q <= i_data;
        o_col_q      <= col_q;
        o_row_q      <= row_q;
      end

      if (i_vs && (state_q != DRAIN)) begin
        state_q <= DRAIN;
      end else begin
        case (state_q)
          IDLE:    state_q <= IDLE;
          DRAIN:   if (fifo_rd_empty) state_q <= FILL;
          FILL:    if (pix_acc && (col_q == COL_LAST)) state_q <= RUN;
          RUN:     state_q <= RUN;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_de         = o_de_q;
  assign o_data_cur   = o_data_cur_q;
  assign o_prev_valid = o_prev_valid_q;
  assign o_col        = o_col_q;
  assign o_row        = o_row_q;
  // Only meaningful in the cycle after a RUN read; forced to 0 otherwise so
  // row 0 and idle cycles never expose leftover FIFO data.
  assign o_data_prev  = o_prev_valid_q ? fifo_rd_data : '0;

`ifdef LINE_SHIFT_ERR_EN
  logic err_q;
  logic err_evt;

  // The offending access is still issued; this only records that it happened.
  assign err_evt = (fifo_wr_en && fifo_wr_full) ||
                   ((state_q == RUN) && fifo_rd_en && fifo_rd_empty) ||
                   ((state_q == DRAIN) && i_de && !i_vs);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_evt) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = fifo_wr_full;
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_shift_ctrl.sv
module tb_line_shift_ctrl;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int CW = 12;
  localparam int DEPTH = 2048;
`ifdef LINE_SHIFT_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_vs = 1'b0;
  logic          i_de = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          fifo_wr_en, fifo_rd_en;
  logic [DW-1:0] fifo_wr_data;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_wr_full, fifo_rd_empty;
  logic          o_de, o_prev_valid, o_err;
  logic [DW-1:0] o_data_cur, o_data_prev;
  logic [CW-1:0] o_col, o_row;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  line_shift_ctrl #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_wr_full(fifo_wr_full), .fifo_rd_empty(fifo_rd_empty),
    .o_de(o_de), .o_data_cur(o_data_cur), .o_data_prev(o_data_prev),
    .o_prev_valid(o_prev_valid), .o_col(o_col), .o_row(o_row), .o_err(o_err)
  );

  // Behavioural FIFO: 1-cycle read latency, cleared by the shared reset.
  logic [DW-1:0] fq[$];
  int            fcount = 0;
  logic          force_empty = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_rd_data <= '0;
      fcount <= 0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (fifo_wr_en && fq.size() < DEPTH) fq.push_back(fifo_wr_data);
      fcount <= fq.size();
    end
  end
  assign fifo_rd_empty = (fcount == 0) || force_empty;
  assign fifo_wr_full  = (fcount >= DEPTH);

  // Reference model: pixel n of a frame sits at column n%LW, row n/LW; its
  // previous-line partner is whatever was stored at that column one row ago.
  logic          chk_en = 1'b0;
  int            m_n = 0;
  logic          m_act = 1'b0;
  logic [DW-1:0] m_line [LW];
  logic          exp_vld = 1'b0;
  logic          exp_pv = 1'b0;
  logic [DW-1:0] exp_cur = '0, exp_prev = '0;
  logic [CW-1:0] exp_col = '0, exp_row = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0; m_n <= 0; exp_vld <= 1'b0;
    end else if (i_vs) begin
      m_act <= 1'b1; m_n <= 0; exp_vld <= 1'b0;
    end else if (i_de && m_act) begin
      exp_vld  <= 1'b1;
      exp_cur  <= i_data;
      exp_col  <= CW'(m_n % LW);
      exp_row  <= (m_n / LW > 4095) ? 12'd4095 : CW'(m_n / LW);
      exp_pv   <= (m_n >= LW);
      exp_prev <= (m_n >= LW) ? m_line[m_n % LW] : '0;
      m_line[m_n % LW] <= i_data;
      m_n <= m_n + 1;
    end else begin
      exp_vld <= 1'b0;
    end
  end

  // Counts DRAIN reads while enabled.
  logic cnt_en = 1'b0;
  int   drain_rd = 0;
  always @(posedge clk) begin
    if (!cnt_en) drain_rd <= 0;
    else if (fifo_rd_en) drain_rd <= drain_rd + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    chk("m_de", 32'(o_de), 32'(exp_vld));
    if (exp_vld) begin
      chk("m_cur", 32'(o_data_cur), 32'(exp_cur));
      chk("m_pv", 32'(o_prev_valid), 32'(exp_pv));
      chk("m_prev", 32'(o_data_prev), 32'(exp_prev));
      chk("m_col", 32'(o_col), 32'(exp_col));
      chk("m_row", 32'(o_row), 32'(exp_row));
    end
  endtask

  // Drive one cycle of inputs just after the edge, then sample at the
  // following negedge (outputs there reflect the previous cycle's inputs).
  task automatic cyc(input logic de, input logic [DW-1:0] d, input logic vs);
    @(posedge clk); #1;
    i_de = de; i_data = d; i_vs = vs;
    @(negedge clk);
    if (chk_en) model_check();
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; i_de = 1'b0; i_vs = 1'b0; force_empty = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start_frame();
    cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    repeat (LW + 3) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic stream(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) cyc(1'b1, base + 8'(k), 1'b0);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          pv;
    logic [DW-1:0] prev;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
  } vec_t;
  vec_t tab[12];

  initial begin
    for (int i = 0; i < 12; i++) begin
      tab[i].d    = 8'(8'h10 + i);
      tab[i].pv   = (i >= 4);
      tab[i].prev = (i >= 4) ? 8'(8'h10 + i - 4) : 8'h00;
      tab[i].col  = CW'(i % 4);
      tab[i].row  = CW'(i / 4);
    end

    // Reset state and IDLE ignoring pixels.
    reset_dut();
    cyc(1'b1, 8'h55, 1'b0);
    chk("rst_o_de", 32'(o_de), 0);
    chk("rst_cur", 32'(o_data_cur), 0);
    chk("rst_prev", 32'(o_data_prev), 0);
    chk("rst_pv", 32'(o_prev_valid), 0);
    chk("rst_col", 32'(o_col), 0);
    chk("rst_row", 32'(o_row), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("idle_wr_en", 32'(fifo_wr_en), 0);
    chk("idle_rd_en", 32'(fifo_rd_en), 0);
    chk("idle_wr_data", 32'(fifo_wr_data), 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_no_de", 32'(o_de), 0);

    // Three back-to-back lines from the table, 1-cycle latency.
    reset_dut();
    start_frame();
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) cyc(1'b1, tab[i].d, 1'b0);
      else cyc(1'b0, 8'h00, 1'b0);
      if (i > 0) begin
        chk($sformatf("t%0d_de", i - 1), 32'(o_de), 1);
        chk($sformatf("t%0d_cur", i - 1), 32'(o_data_cur), 32'(tab[i-1].d));
        chk($sformatf("t%0d_pv", i - 1), 32'(o_prev_valid), 32'(tab[i-1].pv));
        chk($sformatf("t%0d_prev", i - 1), 32'(o_data_prev), 32'(tab[i-1].prev));
        chk($sformatf("t%0d_col", i - 1), 32'(o_col), 32'(tab[i-1].col));
        chk($sformatf("t%0d_row", i - 1), 32'(o_row), 32'(tab[i-1].row));
      end
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("tab_tail_de", 32'(o_de), 0);
    chk("tab_no_err", 32'(o_err), 0);

    // Same stream with random gaps, then random frames with mid-line restarts.
    chk_en = 1'b1;
    reset_dut();
    start_frame();
    for (int i = 0; i < 12; i++) begin
      while ($urandom_range(0, 2) == 0) cyc(1'b0, 8'($urandom), 1'b0);
      cyc(1'b1, 8'(8'h10 + i), 1'b0);
    end
    for (int f = 0; f < 6; f++) begin
      start_frame();
      for (int k = 0; k < int'($urandom_range(0, 30)); k++)
        cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("rand_no_err", 32'(o_err), 0);

    // Restart in row 1: DRAIN empties the line, new frame has no stale data.
    reset_dut();
    start_frame();
    stream(6, 8'h10);
    cyc(1'b1, 8'hEE, 1'b1);
    cnt_en = 1'b1;
    repeat (LW + 3) cyc(1'b0, 8'h00, 1'b0);
    chk("drain_reads", 32'(drain_rd), LW);
    chk("drain_fifo_empty", 32'(fcount), 0);
    cnt_en = 1'b0;
    stream(8, 8'hA0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("vs_de_no_err", 32'(o_err), 0);
    chk_en = 1'b0;

    // Pixel during DRAIN: dropped and (when built) a sticky error.
    reset_dut();
    start_frame();
    stream(6, 8'h20);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("drain_de_dropped", 32'(o_de), 0);
    chk("drain_de_err", 32'(o_err), 32'(ERR_EXP));
    repeat (LW + 3) cyc(1'b0, 8'h00, 1'b0);
    stream(5, 8'h30);
    chk("err_sticky", 32'(o_err), 32'(ERR_EXP));
    reset_dut();
    cyc(1'b0, 8'h00, 1'b0);
    chk("err_cleared", 32'(o_err), 0);

    // Reset mid-RUN at column 2.
    reset_dut();
    start_frame();
    stream(6, 8'h40);
    cyc(1'b1, 8'h33, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 8'h34, 1'b0);
    chk("mid_rst_de", 32'(o_de), 0);
    chk("mid_rst_cur", 32'(o_data_cur), 0);
    chk("mid_rst_prev", 32'(o_data_prev), 0);
    chk("mid_rst_pv", 32'(o_prev_valid), 0);
    chk("mid_rst_col", 32'(o_col), 0);
    chk("mid_rst_row", 32'(o_row), 0);
    chk("mid_rst_err", 32'(o_err), 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 8'(8'h50 + k), 1'b0);
      chk($sformatf("post_rst%0d_wr", k), 32'(fifo_wr_en), 0);
      chk($sformatf("post_rst%0d_de", k), 32'(o_de), 0);
    end

    // Read while the FIFO reports empty in RUN.
    reset_dut();
    start_frame();
    stream(5, 8'h60);
    chk("run_no_err", 32'(o_err), 0);
    cyc(1'b1, 8'h44, 1'b0);
    force_empty = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    force_empty = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    chk("rd_empty_err", 32'(o_err), 32'(ERR_EXP));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
